draw_sequencer: RTL and testbench
=================================

Name: draw_sequencer

Overview:
- Consumer side of the button drawing interface (update/draw/cnext/drawdone plus window and color).
- Round-robin arbitrates among NCLIENTS drawing clients that raise update.
- For the granted client: issues one LCD window command (xstart/xend/ystart/yend), then streams that client's pixel colors to the LCD pixel port, pulsing cnext once per accepted pixel until the client reports drawdone.
- Sits between the button/widget instances and the LCD controller.

Parameters:
- NCLIENTS, 4, number of drawing clients (2..16).
- IDXBITS, 2, width of client index; must satisfy 2**IDXBITS >= NCLIENTS.

Ports:
- clk  in  1  clock.
- arstn  in  1  reset, asynchronous, active-low.
- cl_update  in  NCLIENTS  per-client redraw request.
- cl_drawdone  in  NCLIENTS  per-client done flag; high when idle or finished.
- cl_xstart  in  16*NCLIENTS  window start x; client i at bits [16*i +: 16].
- cl_xend  in  16*NCLIENTS  window end x, inclusive.
- cl_ystart  in  16*NCLIENTS  window start y.
- cl_yend  in  16*NCLIENTS  window end y, inclusive.
- cl_color  in  16*NCLIENTS  current pixel color, RGB565.
- cl_draw  out  NCLIENTS  one-hot draw grant.
- cl_cnext  out  NCLIENTS  one-hot pixel-advance strobe.
- win_valid  out  1  window command valid.
- win_ready  in  1  LCD accepts window command.
- win_xs, win_xe, win_ys, win_ye  out  16 each  latched window coordinates.
- pix_valid  out  1  pixel valid.
- pix_ready  in  1  LCD accepts pixel.
- pix_data  out  16  pixel color; combinational mux of cl_color[cur].
- busy  out  1  high in any state other than IDLE.
- cur_client  out  IDXBITS  index of the granted client.
- err_len  out  1  sticky; pixel count did not match the window area.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = NCLIENTS-1, so client 0 has first priority.
- Reset mid-operation returns to IDLE immediately and drops draw/cnext. Clients reset on the same arstn.
- States:
  - IDLE: if any cl_update is set, pick the first set bit searching upward from last_grant+1 with wrap. Latch cur_client, the window coordinates and area = (xe-xs+1)*(ye-ys+1) as 32 bits. Clear pix_cnt. Go to GRANT. No update set: stay in IDLE.
  - GRANT (1 cycle): cl_draw[cur]=1, held through PIXEL. The client clears update and drops drawdone on the next cycle. Go to WINDOW.
  - WINDOW: win_valid=1 with latched coordinates. On win_valid&&win_ready go to PIXEL.
  - PIXEL:
    - pix_valid = !cl_drawdone[cur].
    - cl_cnext[cur] = pix_valid && pix_ready, combinational, at most one cycle per accepted pixel.
    - pix_cnt increments on each cnext. Back-to-back pixels are legal: the client's color updates the cycle after cnext.
    - When cl_drawdone[cur] is 1: drop draw; set err_len if pix_cnt != area; last_grant = cur; go to RELEASE.
  - RELEASE (1 cycle): draw low so the client can reload its state. Go to IDLE. This gives a minimum 1-cycle gap between draws.
- PIXEL is entered at earliest 2 cycles after draw rises, so the client's stale drawdone=1 is never seen as completion.
- A cl_update for a non-granted client arriving mid-draw is served afterwards. A re-assertion by the current client, e.g. a touch during draw, is served on a later arbitration round.
- pix_ready low stalls with no cnext. pix_data is held by the client because its position is unchanged.
- Coordinates with xe<xs are not checked; area arithmetic wraps mod 2^16 per dimension.
- Out-of-range cur_client index is impossible by construction.

Decomposition:
- Shared package: state encoding (IDLE, GRANT, WINDOW, PIXEL, RELEASE) and RGB565 constant COLOR_WHITE=16'hFFFF.
- Sub-module rr_arbiter (NCLIENTS, IDXBITS): req vector + last_grant in, grant valid + index out, purely combinational.

Test Plan:
- Single client 0, window (10,20)-(13,21), 8 pixels, pix_ready tied 1 → GRANT, 1 win cmd with xs=10 xe=13 ys=20 ye=21, exactly 8 cnext pulses back-to-back, err_len=0, busy low after RELEASE.
- Clients 1 and 3 raise update together after reset → client 1 drawn first, then client 3. With clients 0, 1, 3 all pending after last_grant=1 → service order 3, 0, 1.
- pix_ready toggled 1,0,0,1 on a 4-pixel window → cnext only in ready cycles, pix_data stable during stalls, 4 pixels total.
- win_ready held low 5 cycles → win_valid held steady, no pix_valid until accepted.
- Model client that raises drawdone after 3 pixels of a 4-pixel window → err_len=1 and sticky until reset.
- arstn pulsed low mid-PIXEL → all cl_draw/cl_cnext/win_valid/pix_valid 0 immediately; after release, re-arbitration starts from client 0.

Source files
------------

// File: rtl/draw_sequencer_pkg.sv
// Shared types and helpers for the draw sequencer: FSM state encoding,
// an RGB565 constant and the window-area arithmetic.
package draw_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_WINDOW,
      S_PIXEL,
      S_RELEASE
   } state_t;

   localparam logic [15:0] COLOR_WHITE = 16'hFFFF;

   // Each dimension wraps at 16 bits; the product is kept at 32 bits.
   function automatic logic [31:0] win_area(input logic [15:0] xs, xe, ys, ye);
      logic [15:0] w;
      logic [15:0] h;
      w = xe - xs + 16'd1;
      h = ye - ys + 16'd1;
      return {16'd0, w} * {16'd0, h};
   endfunction

endpackage

// File: rtl/draw_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request above last_grant, with wrap.
module rr_arbiter #(
   parameter int NCLIENTS = 4,
   parameter int IDXBITS  = 2
) (
   input  logic [NCLIENTS-1:0] req,
   input  logic [IDXBITS-1:0]  last_grant,
   output logic                gnt_valid,
   output logic [IDXBITS-1:0]  gnt_idx
);

   // Walk the offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      int k;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      k         = 0;
      for (int i = NCLIENTS; i >= 1; i--) begin
         k = (int'(last_grant) + i) % NCLIENTS;
         if (req[k]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IDXBITS'(k);
         end
      end
   end

endmodule

// File: rtl/draw_sequencer.sv
// Arbitrates drawing clients, sends one LCD window command per draw and
// streams the granted client's pixels, strobing cnext per accepted pixel.
module draw_sequencer
   import draw_sequencer_pkg::*;
#(
   parameter int NCLIENTS = 4,
   parameter int IDXBITS  = 2
) (
   input  logic                    clk,
   input  logic                    arstn,
   input  logic [NCLIENTS-1:0]     cl_update,
   input  logic [NCLIENTS-1:0]     cl_drawdone,
   input  logic [16*NCLIENTS-1:0]  cl_xstart,
   input  logic [16*NCLIENTS-1:0]  cl_xend,
   input  logic [16*NCLIENTS-1:0]  cl_ystart,
   input  logic [16*NCLIENTS-1:0]  cl_yend,
   input  logic [16*NCLIENTS-1:0]  cl_color,
   output logic [NCLIENTS-1:0]     cl_draw,
   output logic [NCLIENTS-1:0]     cl_cnext,
   output logic                    win_valid,
   input  logic                    win_ready,
   output logic [15:0]             win_xs,
   output logic [15:0]             win_xe,
   output logic [15:0]             win_ys,
   output logic [15:0]             win_ye,
   output logic                    pix_valid,
   input  logic                    pix_ready,
   output logic [15:0]             pix_data,
   output logic                    busy,
   output logic [IDXBITS-1:0]      cur_client,
   output logic                    err_len
);

   state_t               state;
   logic [IDXBITS-1:0]   last_grant;
   logic [31:0]          area;
   logic [31:0]          pix_cnt;
   logic                 gnt_valid;
   logic [IDXBITS-1:0]   gnt_idx;
   logic [15:0]          nxs, nxe, nys, nye;
   logic                 cur_done;
   logic                 accept;

   rr_arbiter #(.NCLIENTS(NCLIENTS), .IDXBITS(IDXBITS)) u_arb (
      .req        (cl_update),
      .last_grant (last_grant),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx)
   );

   assign nxs = cl_xstart[16*int'(gnt_idx) +: 16];
   assign nxe = cl_xend  [16*int'(gnt_idx) +: 16];
   assign nys = cl_ystart[16*int'(gnt_idx) +: 16];
   assign nye = cl_yend  [16*int'(gnt_idx) +: 16];

   assign cur_done  = cl_drawdone[cur_client];
   assign pix_valid = (state == S_PIXEL) && !cur_done;
   assign accept    = pix_valid && pix_ready;
   assign cl_cnext  = accept ? (NCLIENTS'(1) << cur_client) : '0;
   assign win_valid = (state == S_WINDOW);
   assign busy      = (state != S_IDLE);
   assign pix_data  = cl_color[16*int'(cur_client) +: 16];

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state      <= S_IDLE;
         last_grant <= IDXBITS'(NCLIENTS-1);
         cur_client <= '0;
         win_xs     <= '0;
         win_xe     <= '0;
         win_ys     <= '0;
         win_ye     <= '0;
         area       <= '0;
         pix_cnt    <= '0;
         cl_draw    <= '0;
         err_len    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (gnt_valid) begin
               cur_client <= gnt_idx;
               win_xs     <= nxs;
               win_xe     <= nxe;
               win_ys     <= nys;
               win_ye     <= nye;
               area       <= win_area(nxs, nxe, nys, nye);
               pix_cnt    <= '0;
               cl_draw    <= NCLIENTS'(1) << gnt_idx;
               state      <= S_GRANT;
            end
            // One dead cycle lets the client drop its stale drawdone.
            S_GRANT:  state <= S_WINDOW;
            S_WINDOW: if (win_ready) state <= S_PIXEL;
            S_PIXEL: begin
               if (accept) pix_cnt <= pix_cnt + 32'd1;
               if (cur_done) begin
                  cl_draw    <= '0;
                  last_grant <= cur_client;
                  if (pix_cnt != area) err_len <= 1'b1;
                  state      <= S_RELEASE;
               end
            end
            S_RELEASE: state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: behavioural clients, a stream monitor,
// table-driven single draws, hand-written corner cases and random rounds.
module tb_draw_sequencer;
   localparam int N  = 4;
   localparam int IB = 2;

   logic clk = 1'b0;
   logic arstn = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    cl_update, cl_drawdone, cl_draw, cl_cnext;
   logic [16*N-1:0] cl_xstart, cl_xend, cl_ystart, cl_yend, cl_color;
   logic            win_valid, pix_valid, busy, err_len;
   logic            win_ready = 1'b1;
   logic            pix_ready = 1'b1;
   logic [15:0]     win_xs, win_xe, win_ys, win_ye, pix_data;
   logic [IB-1:0]   cur_client;

   draw_sequencer #(.NCLIENTS(N), .IDXBITS(IB)) dut (
      .clk(clk), .arstn(arstn), .cl_update(cl_update), .cl_drawdone(cl_drawdone),
      .cl_xstart(cl_xstart), .cl_xend(cl_xend), .cl_ystart(cl_ystart), .cl_yend(cl_yend),
      .cl_color(cl_color), .cl_draw(cl_draw), .cl_cnext(cl_cnext),
      .win_valid(win_valid), .win_ready(win_ready), .win_xs(win_xs), .win_xe(win_xe),
      .win_ys(win_ys), .win_ye(win_ye), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .busy(busy), .cur_client(cur_client), .err_len(err_len)
   );

   // Client k-th pixel color: unique per client and position.
   function automatic logic [15:0] colf(input int c, input int k);
      return 16'((c << 12) | (k & 12'hFFF));
   endfunction

   // ---------------- behavioural clients ----------------
   logic [15:0] xs [N];
   logic [15:0] xe [N];
   logic [15:0] ys [N];
   logic [15:0] ye [N];
   int          npix [N];
   int          req [N];
   int          ack [N];
   int          cnt [N];
   logic        started [N];
   logic [N-1:0] dd;

   always_comb begin
      cl_xstart = '0; cl_xend = '0; cl_ystart = '0; cl_yend = '0; cl_color = '0; cl_update = '0;
      for (int i = 0; i < N; i++) begin
         cl_xstart[16*i +: 16] = xs[i];
         cl_xend[16*i +: 16]   = xe[i];
         cl_ystart[16*i +: 16] = ys[i];
         cl_yend[16*i +: 16]   = ye[i];
         cl_color[16*i +: 16]  = colf(i, cnt[i]);
         cl_update[i]          = (req[i] != ack[i]);
      end
   end
   assign cl_drawdone = dd;

   always @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         for (int i = 0; i < N; i++) begin
            dd[i] <= 1'b1; cnt[i] <= 0; started[i] <= 1'b0; ack[i] <= req[i];
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (cl_draw[i] && !started[i]) begin
               started[i] <= 1'b1; ack[i] <= req[i]; dd[i] <= 1'b0; cnt[i] <= 0;
            end else if (!cl_draw[i]) begin
               started[i] <= 1'b0;
            end
            if (cl_cnext[i]) begin
               cnt[i] <= cnt[i] + 1;
               if (cnt[i] + 1 >= npix[i]) dd[i] <= 1'b1;
            end
         end
      end
   end

   // ---------------- stream monitor ----------------
   int mon_bad = 0;
   int mon_pix = 0;
   int mon_win = 0;
   int order[$];
   logic [N-1:0] prev_draw = '0;

   always @(negedge clk) begin
      if (!arstn) prev_draw = '0;
      else begin
         if (cl_draw != 0 && prev_draw == 0) begin
            order.push_back(int'(cur_client));
            if (cl_draw !== (N'(1) << cur_client)) mon_bad++;
         end
         if (win_valid && win_ready) begin
            mon_win++;
            if ({win_xs, win_xe, win_ys, win_ye} !==
                {xs[cur_client], xe[cur_client], ys[cur_client], ye[cur_client]}) mon_bad++;
         end
         if ((pix_valid && pix_ready) != (cl_cnext != 0)) mon_bad++;
         if (cl_cnext != 0) begin
            mon_pix++;
            if (cl_cnext !== cl_draw || pix_data !== colf(int'(cur_client), cnt[cur_client])) mon_bad++;
         end
         prev_draw = cl_draw;
      end
   end

   // ---------------- checking helpers ----------------
   int nchk = 0;
   int npass = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   function automatic logic [63:0] ocode(input int base);
      logic [63:0] c;
      c = 64'(order.size() - base);
      for (int k = base; k < order.size(); k++) c = (c << 4) | 64'(order[k]);
      return c;
   endfunction

   // Reference arbitration: service order of a pending set raised at once.
   function automatic logic [63:0] rr_model(input logic [N-1:0] m, input int last, output int nlast);
      logic [63:0] c;
      c = 64'($countones(m));
      nlast = last;
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (m[idx]) begin c = (c << 4) | 64'(idx); nlast = idx; end
      end
      return c;
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic setup(input int c, input int x0, input int x1, input int y0, input int y1, input int np);
      xs[c] = 16'(x0); xe[c] = 16'(x1); ys[c] = 16'(y0); ye[c] = 16'(y1); npix[c] = np;
   endtask

   task automatic raise(input int c);
      req[c] = req[c] + 1;
   endtask

   task automatic do_reset();
      arstn = 1'b0;
      step();
      arstn = 1'b1;
   endtask

   task automatic run_until_idle(input bit rnd);
      int c;
      c = 0;
      step();
      while ((busy || cl_update != 0) && c < 3000) begin
         if (rnd) begin
            pix_ready = 1'($urandom_range(0, 1));
            win_ready = 1'($urandom_range(0, 1));
         end
         step();
         c++;
      end
      chk("idle_timeout", 64'(c < 3000), 64'd1);
      pix_ready = 1'b1;
      win_ready = 1'b1;
   endtask

   task automatic wait_sig(input string nm, input bit which);
      int c;
      c = 0;
      while (!(which ? pix_valid : win_valid) && c < 50) begin step(); c++; end
      chk(nm, 64'(c < 50), 64'd1);
   endtask

   typedef struct {
      int          cl;
      logic [15:0] x0, x1, y0, y1;
      int          np;
      logic        err;
   } vec_t;

   initial begin
      vec_t vt[4];
      bit   pat[6];
      int   b, p0, w0, mlast, nl, psum;
      logic [N-1:0] m;
      logic [63:0] ec;

      for (int i = 0; i < N; i++) begin req[i] = 0; setup(i, 0, 0, 0, 0, 1); end
      vt[0] = '{0, 16'd10, 16'd13, 16'd20, 16'd21, 8, 1'b0};
      vt[1] = '{2, 16'd0, 16'd1, 16'd0, 16'd1, 4, 1'b0};
      vt[2] = '{1, 16'd100, 16'd100, 16'd5, 16'd9, 5, 1'b0};
      vt[3] = '{3, 16'd7, 16'd7, 16'd7, 16'd7, 1, 1'b0};
      pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      // reset state
      step();
      chk("rst_ctrl", {cl_draw, cl_cnext, win_valid, pix_valid, busy, err_len, cur_client}, 64'd0);
      chk("rst_win", {win_xs, win_xe, win_ys, win_ye}, 64'd0);
      arstn = 1'b1;
      step();

      // table-driven single-client draws
      for (int v = 0; v < 4; v++) begin
         setup(vt[v].cl, vt[v].x0, vt[v].x1, vt[v].y0, vt[v].y1, vt[v].np);
         b = order.size(); p0 = mon_pix; w0 = mon_win; ec = 64'(mon_bad);
         raise(vt[v].cl);
         run_until_idle(1'b0);
         chk("tbl_order", ocode(b), 64'h10 | 64'(vt[v].cl));
         chk("tbl_pixels", 64'(mon_pix - p0), 64'(vt[v].np));
         chk("tbl_windows", 64'(mon_win - w0), 64'd1);
         chk("tbl_stream", 64'(mon_bad), ec);
         chk("tbl_err", 64'(err_len), 64'(vt[v].err));
         chk("tbl_busy", 64'(busy), 64'd0);
      end

      // pix_ready 1,0,0,1,... on a 4-pixel window
      setup(2, 0, 1, 0, 1, 4);
      p0 = mon_pix;
      pix_ready = 1'b0;
      raise(2);
      wait_sig("tog_wait", 1'b1);
      for (int k = 0; k < 6; k++) begin
         pix_ready = pat[k];
         #1;
         chk("tog_cnext", 64'(cl_cnext), pat[k] ? 64'h4 : 64'h0);
         if (!pat[k]) chk("tog_hold", 64'(pix_data), 64'(colf(2, 1)));
         step();
      end
      pix_ready = 1'b1;
      run_until_idle(1'b0);
      chk("tog_pixels", 64'(mon_pix - p0), 64'd4);

      // window command stalled 5 cycles
      setup(0, 1, 3, 2, 4, 6);
      p0 = mon_pix; w0 = mon_win;
      win_ready = 1'b0;
      raise(0);
      wait_sig("win_wait", 1'b0);
      for (int k = 0; k < 5; k++) begin
         chk("win_hold", {win_valid, pix_valid, win_xs, win_xe, win_ys, win_ye},
             {1'b1, 1'b0, 16'd1, 16'd3, 16'd2, 16'd4});
         step();
      end
      win_ready = 1'b1;
      run_until_idle(1'b0);
      chk("win_pixels", 64'(mon_pix - p0), 64'd6);
      chk("win_count", 64'(mon_win - w0), 64'd1);

      // arbitration order
      do_reset();
      setup(1, 5, 6, 5, 5, 2); setup(3, 8, 8, 1, 3, 3); setup(0, 0, 0, 0, 0, 1);
      b = order.size();
      raise(1); raise(3);
      run_until_idle(1'b0);
      chk("arb_13", ocode(b), 64'h213);
      raise(1);
      run_until_idle(1'b0);
      b = order.size();
      raise(0); raise(1); raise(3);
      run_until_idle(1'b0);
      chk("arb_301", ocode(b), 64'h3301);

      // short client -> sticky length error
      setup(3, 0, 1, 0, 1, 3);
      raise(3);
      run_until_idle(1'b0);
      chk("err_set", 64'(err_len), 64'd1);
      setup(0, 0, 0, 0, 0, 1);
      raise(0);
      run_until_idle(1'b0);
      chk("err_sticky", 64'(err_len), 64'd1);
      do_reset();
      chk("err_clear", 64'(err_len), 64'd0);

      // reset in the middle of a pixel stream
      setup(2, 0, 9, 0, 9, 100);
      raise(2);
      wait_sig("mid_wait", 1'b1);
      step(); step();
      arstn = 1'b0;
      #1;
      chk("mid_rst", {cl_draw, cl_cnext, win_valid, pix_valid, busy}, 64'd0);
      step();
      arstn = 1'b1;
      setup(0, 4, 4, 4, 5, 2); setup(2, 0, 0, 0, 1, 2);
      b = order.size();
      raise(0); raise(2);
      run_until_idle(1'b0);
      chk("mid_order", ocode(b), 64'h202);

      // random rounds against the round-robin model
      do_reset();
      mlast = N - 1;
      for (int r = 0; r < 25; r++) begin
         m = N'($urandom_range(1, (1 << N) - 1));
         psum = 0;
         for (int c = 0; c < N; c++) if (m[c]) begin
            int x0, y0, w, h;
            x0 = $urandom_range(0, 300); y0 = $urandom_range(0, 200);
            w = $urandom_range(1, 4); h = $urandom_range(1, 4);
            setup(c, x0, x0 + w - 1, y0, y0 + h - 1, w * h);
            psum += w * h;
         end
         ec = rr_model(m, mlast, nl);
         b = order.size(); p0 = mon_pix; w0 = mon_bad;
         for (int c = 0; c < N; c++) if (m[c]) raise(c);
         run_until_idle(1'b1);
         chk("rnd_order", ocode(b), ec);
         chk("rnd_pixels", 64'(mon_pix - p0), 64'(psum));
         chk("rnd_stream", 64'(mon_bad - w0), 64'd0);
         mlast = nl;
      end
      chk("rnd_err", 64'(err_len), 64'd0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
